// File: rtl/pc_sequencer.sv
// Program-counter sequencer and instruction-fetch handshake for the single-cycle MIPS core.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic        align_err,
    output logic [31:0] retire_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              imem_req_q;
    logic              instr_valid_q;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   instr_pc_q;
    logic              align_err_q;
    logic [XLEN-1:0]   retire_cnt_q;

    logic              redirect_c;
    logic [XLEN-1:0]   redirect_tgt_c;
    logic [XLEN-1:0]   pc_d;
    logic              misaligned_c;
    logic              consume_c;

    // Next-PC select: jump beats branch, otherwise sequential with natural 32-bit wrap.
    always_comb begin
        redirect_c     = 1'b0;
        redirect_tgt_c = '0;
        if (jump) begin
            redirect_c     = 1'b1;
            redirect_tgt_c = jump_target;
        end else if (branch_taken) begin
            redirect_c     = 1'b1;
            redirect_tgt_c = branch_target;
        end
        misaligned_c = redirect_c && (redirect_tgt_c[1:0] != 2'b00);
        pc_d         = redirect_c ? {redirect_tgt_c[XLEN-1:2], 2'b00}
                                  : pc_q + XLEN'(4);
    end

    assign consume_c = (state_q == HOLD) && !stall;

    // Fetch FSM with registered handshake, instruction latch, PC and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            align_err_q   <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_q       <= HOLD;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                    end
                end
                HOLD: begin
                    if (consume_c) begin
                        state_q       <= FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                        pc_q          <= pc_d;
                        retire_cnt_q  <= retire_cnt_q + XLEN'(1);
                        if (misaligned_c) begin
                            align_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign align_err   = align_err_q;
    assign retire_cnt  = retire_cnt_q;

endmodule
